// File: rtl/sd_cmd_engine.sv
`default_nettype none
// ============================================================================
// sd_cmd_engine : serialises one 48-bit SD command, then captures an R1/R7
//                 response or flags a timeout, then holds CS high for a gap.
// Revision      : 1.0
// ============================================================================
module sd_cmd_engine #(
  parameter int TIMEOUT  = 255,
  parameter int GAP_CLKS = 8
) (
  input  logic        SD_CLK,
  input  logic        rst,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic [47:0] cmd_data_i,
  input  logic [5:0]  resp_len_i,
  output logic        resp_valid_o,
  output logic [47:0] resp_data_o,
  output logic        resp_timeout_o,
  output logic        busy_o,
  output logic        SD_CS_o,
  output logic        SD_DATAIN_o,
  input  logic        SD_DATAOUT_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
    S_WAIT = 3'd2,
    S_RECV = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CLKS - 1);
  localparam logic [5:0] TX_LAST  = 6'd47;

  state_t      state_q, state_d;
  logic [47:0] tx_sh_q, tx_sh_d;
  logic [46:0] rx_sh_q, rx_sh_d;
  logic [5:0]  tx_cnt_q, tx_cnt_d;
  logic [5:0]  rx_cnt_q, rx_cnt_d;
  logic [7:0]  timer_q, timer_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [5:0]  len_q, len_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        busy_q, busy_d;
  logic        resp_valid_q, resp_valid_d;
  logic        resp_timeout_q, resp_timeout_d;
  logic [47:0] resp_data_q, resp_data_d;
  logic        cs_q, cs_d;
  logic        datain_q, datain_d;

  logic [5:0]  len_clamped;
  logic [47:0] rx_shift;

  // Out-of-range lengths fall back to the longest frame the engine can hold.
  assign len_clamped = (resp_len_i == 6'd0 || resp_len_i > 6'd48) ? 6'd48 : resp_len_i;
  assign rx_shift    = {rx_sh_q, SD_DATAOUT_i};

  always_comb begin
    state_d        = state_q;
    tx_sh_d        = tx_sh_q;
    rx_sh_d        = rx_sh_q;
    tx_cnt_d       = tx_cnt_q;
    rx_cnt_d       = rx_cnt_q;
    timer_d        = timer_q;
    gap_cnt_d      = gap_cnt_q;
    len_d          = len_q;
    cmd_ready_d    = cmd_ready_q;
    busy_d         = busy_q;
    resp_valid_d   = 1'b0;
    resp_timeout_d = 1'b0;
    resp_data_d    = resp_data_q;
    cs_d           = cs_q;
    datain_d       = datain_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          state_d     = S_SEND;
          datain_d    = cmd_data_i[47];
          tx_sh_d     = {cmd_data_i[46:0], 1'b0};
          tx_cnt_d    = 6'd0;
          rx_sh_d     = '0;
          len_d       = len_clamped;
          cs_d        = 1'b0;
          cmd_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end

      S_SEND: begin
        if (tx_cnt_q >= TX_LAST) begin
          state_d  = S_WAIT;
          datain_d = 1'b1;
          timer_d  = 8'd0;
        end else begin
          datain_d = tx_sh_q[47];
          tx_sh_d  = {tx_sh_q[46:0], 1'b0};
          tx_cnt_d = tx_cnt_q + 6'd1;
        end
      end

      S_WAIT: begin
        // A low sample is the start bit even on the final timer count.
        if (!SD_DATAOUT_i) begin
          rx_sh_d  = rx_shift[46:0];
          rx_cnt_d = len_q - 6'd1;
          if (len_q == 6'd1) begin
            resp_data_d  = rx_shift;
            resp_valid_d = 1'b1;
            state_d      = S_GAP;
            cs_d         = 1'b1;
            gap_cnt_d    = 4'd0;
          end else begin
            state_d = S_RECV;
          end
        end else if (timer_q == TMO_LAST) begin
          resp_timeout_d = 1'b1;
          resp_data_d    = {48{1'b1}};
          state_d        = S_GAP;
          cs_d           = 1'b1;
          gap_cnt_d      = 4'd0;
        end else if (timer_q != 8'hFF) begin
          timer_d = timer_q + 8'd1;
        end
      end

      S_RECV: begin
        rx_sh_d = rx_shift[46:0];
        if (rx_cnt_q != 6'd0) begin
          rx_cnt_d = rx_cnt_q - 6'd1;
        end
        if (rx_cnt_q <= 6'd1) begin
          resp_data_d  = rx_shift;
          resp_valid_d = 1'b1;
          state_d      = S_GAP;
          cs_d         = 1'b1;
          gap_cnt_d    = 4'd0;
        end
      end

      S_GAP: begin
        if (gap_cnt_q >= GAP_LAST) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
          busy_d      = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cmd_ready_d = 1'b1;
        busy_d      = 1'b0;
        cs_d        = 1'b1;
        datain_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge SD_CLK) begin
    if (rst) begin
      state_q        <= S_IDLE;
      tx_sh_q        <= '0;
      rx_sh_q        <= '0;
      tx_cnt_q       <= 6'd0;
      rx_cnt_q       <= 6'd0;
      timer_q        <= 8'd0;
      gap_cnt_q      <= 4'd0;
      len_q          <= 6'd0;
      cmd_ready_q    <= 1'b1;
      busy_q         <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_timeout_q <= 1'b0;
      resp_data_q    <= '0;
      cs_q           <= 1'b1;
      datain_q       <= 1'b1;
    end else begin
      state_q        <= state_d;
      tx_sh_q        <= tx_sh_d;
      rx_sh_q        <= rx_sh_d;
      tx_cnt_q       <= tx_cnt_d;
      rx_cnt_q       <= rx_cnt_d;
      timer_q        <= timer_d;
      gap_cnt_q      <= gap_cnt_d;
      len_q          <= len_d;
      cmd_ready_q    <= cmd_ready_d;
      busy_q         <= busy_d;
      resp_valid_q   <= resp_valid_d;
      resp_timeout_q <= resp_timeout_d;
      resp_data_q    <= resp_data_d;
      cs_q           <= cs_d;
      datain_q       <= datain_d;
    end
  end

  assign cmd_ready_o    = cmd_ready_q;
  assign busy_o         = busy_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_timeout_o = resp_timeout_q;
  assign resp_data_o    = resp_data_q;
  assign SD_CS_o        = cs_q;
  assign SD_DATAIN_o    = datain_q;

endmodule
`default_nettype wire
